hs_rx_fifo: RTL and testbench



---
 rtl/hs_rx_fifo_if.sv | 25 ++
 rtl/hs_rx_fifo.sv | 120 ++++++++++++
 tb/tb_hs_rx_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/hs_rx_fifo_if.sv
// hs_rx_fifo_if: request/ack capture side and FWFT valid/ready side of the domain-B receiver.
// The slave modport is the receiver; master is the sender/consumer environment.
interface hs_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
);
  logic              breq;
  logic [DATA_W-1:0] adata;
  logic              back;
  logic [DATA_W-1:0] bdata;
  logic              bvalid;
  logic              bready;
  logic [CNT_W-1:0]  bcount;
  logic [1:0]        bstate;

  modport master (
    output breq, adata, bready,
    input  back, bdata, bvalid, bcount, bstate
  );

  modport slave (
    input  breq, adata, bready,
    output back, bdata, bvalid, bcount, bstate
  );
endinterface

// File: rtl/hs_rx_fifo.sv
// hs_rx_fifo: domain-B end of a 4-phase req/ack CDC handshake, capturing words into a FWFT FIFO.
// Define HS_RX_STALL_CNT_EN to add bstall_cnt, a saturating count of cycles spent in STALL.
module hs_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic       bclk,
  input  logic       brst,
`ifdef HS_RX_STALL_CNT_EN
  output logic [7:0] bstall_cnt,
`endif
  hs_rx_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACK     = 2'b01,
    STALL   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic              back_q, back_nxt;
  logic              push, pop, full, empty;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mem [DEPTH];

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && bus.bready;

  always_comb begin
    state_nxt = state;
    back_nxt  = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.breq) begin
          if (!full) begin
            push      = 1'b1;
            back_nxt  = 1'b1;
            state_nxt = ACK;
          end else begin
            state_nxt = STALL;
          end
        end
      end
      ACK: begin
        back_nxt = 1'b1;
        if (!bus.breq) begin
          back_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      STALL: begin
        // A dropped request means the sender was reset; abandon the pending word.
        if (!bus.breq) begin
          state_nxt = IDLE;
        end else if (!full) begin
          push      = 1'b1;
          back_nxt  = 1'b1;
          state_nxt = ACK;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge bclk) begin
    if (brst) begin
      state  <= IDLE;
      back_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      back_q <= back_nxt;
    end
  end

  always_ff @(posedge bclk) begin
    if (brst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge bclk) begin
    if (push) mem[wr_ptr] <= bus.adata;
  end

`ifdef HS_RX_STALL_CNT_EN
  always_ff @(posedge bclk) begin
    if (brst) begin
      bstall_cnt <= 8'h00;
    end else if (state == STALL && bstall_cnt != 8'hFF) begin
      bstall_cnt <= bstall_cnt + 8'h01;
    end
  end
`endif

  assign bus.back   = back_q;
  assign bus.bdata  = mem[rd_ptr];
  assign bus.bvalid = !empty;
  assign bus.bcount = count;
  assign bus.bstate = state;
endmodule

// File: tb/tb_hs_rx_fifo.sv
// tb_hs_rx_fifo: table-driven vectors plus directed sequences for wrap, push/pop overlap and reset.
// Define HS_RX_STALL_CNT_EN to also exercise the stall counter.
module tb_hs_rx_fifo;
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ACK   = 2'b01;
  localparam logic [1:0] S_STALL = 2'b10;

  typedef struct {
    logic       brst;
    logic       breq;
    logic       bready;
    logic [7:0] adata;
    logic       exp_back;
    logic       exp_bvalid;
    logic [7:0] exp_bdata;
    logic [2:0] exp_bcount;
    logic [1:0] exp_bstate;
  } vec_t;

  logic bclk;
  logic brst;
  int   checks;
  int   errors;
  int   rx_idx;
  vec_t vecs [26];

`ifdef HS_RX_STALL_CNT_EN
  logic [7:0] bstall_cnt;
`endif

  hs_rx_fifo_if #(.DATA_W(8), .CNT_W(3)) bus ();

  hs_rx_fifo #(.DATA_W(8), .DEPTH(4), .CNT_W(3)) dut (
    .bclk       (bclk),
    .brst       (brst),
`ifdef HS_RX_STALL_CNT_EN
    .bstall_cnt (bstall_cnt),
`endif
    .bus        (bus)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  task automatic applyStimulus(input logic rst, input logic req, input logic rdy,
                               input logic [7:0] data);
    brst       = rst;
    bus.breq   = req;
    bus.bready = rdy;
    bus.adata  = data;
  endtask

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic transfer(input logic [7:0] data, input logic rdy);
    applyStimulus(1'b0, 1'b1, rdy, data);
    tick();
    applyStimulus(1'b0, 1'b0, rdy, data);
    tick();
  endtask

  task automatic sample_wrap();
    checks++;
    if (bus.bcount > 3'd2) begin
      errors++;
      $display("[TB] FAIL wrap_cnt_max got %0d expected <= 2 at %0t", bus.bcount, $time);
    end
    if (bus.bvalid) begin
      checkOutput("wrap_data", bus.bdata, 8'(8'h10 + rx_idx));
      rx_idx++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

    // single transfer, then a burst that overfills and stalls
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, S_IDLE};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 3'd1, S_ACK};
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = vecs[1];
    vecs[5]  = vecs[1];
    vecs[6]  = vecs[1];
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 3'd1, S_IDLE};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, S_IDLE};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 8'h01, 3'd1, S_ACK};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 8'h01, 3'd1, S_IDLE};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 8'h01, 3'd2, S_ACK};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1, 8'h01, 3'd2, S_IDLE};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 8'h01, 3'd3, S_ACK};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 8'h01, 3'd3, S_IDLE};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 8'h01, 3'd4, S_ACK};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h04, 1'b0, 1'b1, 8'h01, 3'd4, S_IDLE};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 8'h01, 3'd4, S_STALL};
    vecs[18] = vecs[17];
    vecs[19] = '{1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 8'h02, 3'd3, S_STALL};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 8'h02, 3'd4, S_ACK};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 8'h02, 3'd4, S_IDLE};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h03, 3'd3, S_IDLE};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h04, 3'd2, S_IDLE};
    vecs[24] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h05, 3'd1, S_IDLE};
    vecs[25] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, S_IDLE};

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].brst, vecs[i].breq, vecs[i].bready, vecs[i].adata);
      tick();
      checkOutput($sformatf("vec%0d_back", i), 8'(bus.back), 8'(vecs[i].exp_back));
      checkOutput($sformatf("vec%0d_bvalid", i), 8'(bus.bvalid), 8'(vecs[i].exp_bvalid));
      checkOutput($sformatf("vec%0d_bcount", i), 8'(bus.bcount), 8'(vecs[i].exp_bcount));
      checkOutput($sformatf("vec%0d_bstate", i), 8'(bus.bstate), 8'(vecs[i].exp_bstate));
      if (vecs[i].exp_bvalid)
        checkOutput($sformatf("vec%0d_bdata", i), bus.bdata, vecs[i].exp_bdata);
    end

    // pointer wrap with the consumer always ready
    $display("[TB] pointer wrap");
    do_reset();
    rx_idx = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'(8'h10 + i));
      tick();
      sample_wrap();
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
      tick();
      sample_wrap();
    end
    checkOutput("wrap_total", 8'(rx_idx), 8'd10);

    // push and pop on the same edge with two words held
    $display("[TB] simultaneous push and pop");
    do_reset();
    transfer(8'h20, 1'b0);
    transfer(8'h21, 1'b0);
    checkOutput("pp_pre_cnt", 8'(bus.bcount), 8'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h22);
    tick();
    checkOutput("pp_cnt", 8'(bus.bcount), 8'd2);
    checkOutput("pp_head", bus.bdata, 8'h21);
    checkOutput("pp_state", 8'(bus.bstate), 8'(S_ACK));
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    checkOutput("pp_next", bus.bdata, 8'h22);
    checkOutput("pp_next_cnt", 8'(bus.bcount), 8'd1);
    tick();
    checkOutput("pp_empty", 8'(bus.bvalid), 8'd0);

    // reset while acknowledging with request still high
    $display("[TB] reset mid-transfer");
    do_reset();
    transfer(8'h30, 1'b0);
    transfer(8'h31, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h32);
    tick();
    checkOutput("rst_pre_cnt", 8'(bus.bcount), 8'd3);
    checkOutput("rst_pre_state", 8'(bus.bstate), 8'(S_ACK));
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h32);
    tick();
    checkOutput("rst_cnt", 8'(bus.bcount), 8'd0);
    checkOutput("rst_back", 8'(bus.back), 8'd0);
    checkOutput("rst_bvalid", 8'(bus.bvalid), 8'd0);
    checkOutput("rst_state", 8'(bus.bstate), 8'(S_IDLE));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h32);
    tick();
    checkOutput("rst_recap_cnt", 8'(bus.bcount), 8'd1);
    checkOutput("rst_recap_state", 8'(bus.bstate), 8'(S_ACK));
    checkOutput("rst_recap_back", 8'(bus.back), 8'd1);
    checkOutput("rst_recap_data", bus.bdata, 8'h32);

`ifdef HS_RX_STALL_CNT_EN
    $display("[TB] stall counter saturation");
    do_reset();
    checkOutput("stc_reset", bstall_cnt, 8'h00);
    for (int i = 0; i < 4; i++) transfer(8'(8'h40 + i), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h44);
    tick();
    checkOutput("stc_state", 8'(bus.bstate), 8'(S_STALL));
    checkOutput("stc_enter", bstall_cnt, 8'h00);
    tick();
    checkOutput("stc_first", bstall_cnt, 8'h01);
    for (int i = 0; i < 300; i++) tick();
    checkOutput("stc_sat", bstall_cnt, 8'hFF);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("stc_hold", bstall_cnt, 8'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
